// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
//
// Runs one memory transaction at a time and routes each response back to the requester that owns it.
// Arbitration favours load/store. After STARVE_LIMIT consecutive data grants made while a fetch is
// waiting, the fetch is forced to win. An optional watchdog completes a transaction whose response
// never arrives.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   inst_req/addr -> inst_gnt    fetch request and its combinational accept (IDLE only)
//   inst_rvalid/rdata            fetch response, one-cycle pulse
//   data_req/we/wstrb/addr/wdata load/store request
//   data_gnt                     load/store accept (IDLE only)
//   data_rvalid/rdata            load/store response, one-cycle pulse; rdata is 0 for a store
//   mem_req/we/wstrb/addr/wdata  request to memory, held stable until mem_ready
//   mem_ready                    memory takes the request on this edge
//   mem_rvalid/rdata             memory response
//   timeout_err                  one-cycle pulse when the watchdog completes a transaction

module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic            inst_gnt,
  output logic            inst_rvalid,
  output logic [DW-1:0]   inst_rdata,
  input  logic            data_req,
  input  logic            data_we,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_gnt,
  output logic            data_rvalid,
  output logic [DW-1:0]   data_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WD_LAST    = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic          WD_EN      = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              owner_data_q;
  logic [AW-1:0]     addr_q;
  logic              we_q;
  logic [DW/8-1:0]   wstrb_q;
  logic [DW-1:0]     wdata_q;
  logic [SW-1:0]     streak_q;
  logic [WW-1:0]     wd_q;

  logic              in_idle;
  logic              inst_wins;
  logic              data_wins;
  logic              wd_fire;
  logic              resp_done;
  logic [DW-1:0]     resp_data;

  assign in_idle = (state_q == S_IDLE);

  // Data has priority unless the fetch has already lost STARVE_LIMIT grants in a row.
  assign inst_wins = inst_req && (!data_req || (streak_q == STREAK_MAX));
  assign data_wins = data_req && !inst_wins;

  // Grants are suppressed while rst is high because the reset edge would discard the latch.
  assign inst_gnt = in_idle && !rst && inst_wins;
  assign data_gnt = in_idle && !rst && data_wins;

  // The watchdog fires on the last counted RESP cycle when no response has arrived.
  assign wd_fire   = WD_EN && (state_q == S_RESP) && !mem_rvalid && (wd_q == WD_LAST);
  assign resp_done = (state_q == S_RESP) && (mem_rvalid || wd_fire);

  always_comb begin
    resp_data = '0;
    // A store acknowledges with zero data; a watchdog completion also returns zero.
    if (mem_rvalid && !(owner_data_q && we_q)) begin
      resp_data = mem_rdata;
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_wstrb = mem_req ? wstrb_q : '0;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (inst_gnt || data_gnt) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_data_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      streak_q     <= '0;
      wd_q         <= '0;
      inst_rvalid  <= 1'b0;
      inst_rdata   <= '0;
      data_rvalid  <= 1'b0;
      data_rdata   <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_rvalid <= 1'b0;
      inst_rdata  <= '0;
      data_rvalid <= 1'b0;
      data_rdata  <= '0;
      timeout_err <= 1'b0;

      if (inst_gnt) begin
        owner_data_q <= 1'b0;
        addr_q       <= inst_addr;
        we_q         <= 1'b0;
        wstrb_q      <= '0;
        wdata_q      <= '0;
      end else if (data_gnt) begin
        owner_data_q <= 1'b1;
        addr_q       <= data_addr;
        we_q         <= data_we;
        wstrb_q      <= data_wstrb;
        wdata_q      <= data_wdata;
      end

      // The streak only moves on IDLE cycles, where arbitration actually happens.
      if (in_idle) begin
        if (inst_gnt || !inst_req) begin
          streak_q <= '0;
        end else if (data_gnt && (streak_q != STREAK_MAX)) begin
          streak_q <= streak_q + SW'(1);
        end
      end

      if (state_q == S_RESP) begin
        wd_q <= wd_q + WW'(1);
      end else begin
        wd_q <= '0;
      end

      if (resp_done) begin
        timeout_err <= wd_fire;
        if (owner_data_q) begin
          data_rvalid <= 1'b1;
          data_rdata  <= resp_data;
        end else begin
          inst_rvalid <= 1'b1;
          inst_rdata  <= resp_data;
        end
      end
    end
  end

endmodule
